xstack_monitor: RTL and testbench
=================================

XSTACK_MONITOR -- requirements
Module: xstack_monitor

Interface
REQ-001 SHALL have parameter NREG, default 4, meaning number of protected data regions (1..8).
REQ-002 SHALL have parameter REG_BASE, default {16'hFEFE,16'h9000,16'h8000,16'hA000}, meaning packed 16*NREG region first addresses (region 0 in LSBs).
REQ-003 SHALL have parameter REG_LAST, default {16'hFF1C,16'h901F,16'h801E,16'hAFFF}, meaning packed 16*NREG inclusive region last addresses.
REQ-004 SHALL have parameter REG_SECRET, default 4'b1001, meaning NREG-bit mask of regions untrusted code may neither read nor write.
REQ-005 SHALL have parameter REG_TRW, default 4'b0111, meaning NREG-bit mask of regions trusted code may write.
REQ-006 SHALL have parameter REG_UWP, default 4'b0100, meaning NREG-bit mask of regions untrusted code may read but not write.
REQ-007 SHALL have parameter TCB_BASE, default 16'hE000, meaning first address of trusted code.
REQ-008 SHALL have parameter TCB_LAST, default 16'hEFFE, meaning inclusive last address of trusted code.
REQ-009 SHALL have parameter RESET_HANDLER, default 16'hFFFE, meaning PC value that permits leaving KILL.
REQ-010 SHALL have parameter HOLD_MIN, default 4, meaning minimum KILL cycles (>=1, <=255).
REQ-011 SHALL have port clk  input  1  system clock, all flops on rising edge.
REQ-012 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-013 SHALL have port pc  input  16  current program counter.
REQ-014 SHALL have port data_addr  input  16  data bus address.
REQ-015 SHALL have port r_en  input  1  data read strobe.
REQ-016 SHALL have port w_en  input  1  data write strobe.
REQ-017 SHALL have port clr_log  input  1  synchronous clear of violation log.
REQ-018 SHALL have port reset  output  1  CPU reset request, active-high.
REQ-019 SHALL have port viol_cause  output  3  logged cause: bit0 V1, bit1 V2, bit2 V3.
REQ-020 SHALL have port viol_addr  output  16  logged data_addr of first violation.
REQ-021 SHALL have port viol_cnt  output  8  count of RUN->KILL transitions, saturating.

Function
REQ-022 SHALL decode trusted = TCB_BASE <= pc <= TCB_LAST and hit[i] = REG_BASE[i] <= data_addr <= REG_LAST[i], unsigned 16-bit compares.
REQ-023 SHALL flag V1 = !trusted && (r_en||w_en) && any hit[i] with REG_SECRET[i].
REQ-024 SHALL flag V2 = trusted && w_en && no hit[i] with REG_TRW[i].
REQ-025 SHALL flag V3 = !trusted && w_en && any hit[i] with REG_UWP[i]; viol = V1|V2|V3.
REQ-026 SHALL implement registered two-state FSM RUN/KILL plus 8-bit hold counter hcnt.
REQ-027 SHALL go RUN->KILL on the clock edge where viol is high in RUN, loading hcnt = HOLD_MIN-1.
REQ-028 SHALL in KILL decrement hcnt each cycle, saturating at 0.
REQ-029 SHALL define exit = (hcnt==0) && (pc==RESET_HANDLER) && !viol, and go KILL->RUN on the edge where exit is high.
REQ-030 SHALL drive reset combinationally = (RUN && viol) || (KILL && !exit); zero-latency assertion, same-cycle release on exit.
REQ-031 SHALL ignore further violations in KILL for logging; they only block exit.
REQ-032 SHALL on every RUN->KILL edge capture viol_cause={V3,V2,V1} and viol_addr=data_addr, and increment viol_cnt saturating at 8'hFF.
REQ-033 SHALL on clr_log clear viol_cause, viol_addr and viol_cnt next edge; simultaneous RUN->KILL wins: capture new values, viol_cnt=1.
REQ-034 SHALL treat overlapping regions by OR of matching mask bits.

Reset
REQ-035 SHALL on reset_n low asynchronously set state=RUN, hcnt=0, viol_cause=0, viol_addr=0, viol_cnt=0.
REQ-036 SHALL while reset_n low drive reset from combinational viol only (RUN term).

Configuration
REQ-037 SHALL with XSTACK_VIOL_LOG_EN defined implement REQ-032/033 log registers.
REQ-038 SHALL without XSTACK_VIOL_LOG_EN instantiate no log flops, tie viol_cause/viol_addr/viol_cnt to 0, ignore clr_log; FSM and reset unchanged.

Verification
REQ-039 SHALL test pc=16'h4000, r_en=1, data_addr=16'hA010 -> reset=1 same cycle, KILL next, viol_cause=3'b001, viol_addr=16'hA010, viol_cnt=1.
REQ-040 SHALL test pc=16'hE100, w_en=1, data_addr=16'h0200 -> V2, reset=1; data_addr=16'h9004 instead -> reset=0.
REQ-041 SHALL test pc=16'h4000, w_en=1, data_addr=16'h9000 -> V3; r_en only -> no reset.
REQ-042 SHALL test KILL with pc=16'hFFFE from first KILL cycle, HOLD_MIN=4 -> reset high 4 cycles incl. violation cycle, low in 4th KILL cycle, RUN after.
REQ-043 SHALL test 300 separate violations then clr_log together with violation -> viol_cnt 255 then 1.
REQ-044 SHALL test reset_n low mid-KILL with hcnt=2 -> state RUN, counters 0 immediately, reset=0 with no violation.

Source files
------------

// File: rtl/xstack_monitor.sv
// xstack_monitor: data-access isolation monitor for a small CPU.
// Classifies every data access against protected regions and a trusted code
// block, asserts a combinational CPU reset on a violation, and holds reset in
// a KILL state for at least HOLD_MIN cycles until the CPU reaches the reset
// handler with a clean access.
// Optional build macro XSTACK_VIOL_LOG_EN adds the violation log registers
// (viol_cause/viol_addr/viol_cnt); without it those outputs are tied to zero.
module xstack_monitor #(
  parameter int unsigned        NREG          = 4,
  parameter logic [16*NREG-1:0] REG_BASE      = {16'hFEFE, 16'h9000, 16'h8000, 16'hA000},
  parameter logic [16*NREG-1:0] REG_LAST      = {16'hFF1C, 16'h901F, 16'h801E, 16'hAFFF},
  parameter logic [NREG-1:0]    REG_SECRET    = 4'b1001,
  parameter logic [NREG-1:0]    REG_TRW       = 4'b0111,
  parameter logic [NREG-1:0]    REG_UWP       = 4'b0100,
  parameter logic [15:0]        TCB_BASE      = 16'hE000,
  parameter logic [15:0]        TCB_LAST      = 16'hEFFE,
  parameter logic [15:0]        RESET_HANDLER = 16'hFFFE,
  parameter int unsigned        HOLD_MIN      = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] pc,
  input  logic [15:0] data_addr,
  input  logic        r_en,
  input  logic        w_en,
  input  logic        clr_log,
  output logic        reset,
  output logic [2:0]  viol_cause,
  output logic [15:0] viol_addr,
  output logic [7:0]  viol_cnt
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_KILL = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_MIN - 1);

  state_t          state;
  state_t          state_nxt;
  logic [7:0]      hcnt;
  logic [7:0]      hcnt_nxt;

  logic            trusted;
  logic [NREG-1:0] hit;
  logic            secret_hit;
  logic            trw_hit;
  logic            uwp_hit;
  logic            v1;
  logic            v2;
  logic            v3;
  logic            viol;
  logic            exit_ok;

  // Address decode: trusted-code window and per-region hits (overlaps OR together).
  always_comb begin
    trusted = (pc >= TCB_BASE) && (pc <= TCB_LAST);
    hit     = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      hit[i] = (data_addr >= REG_BASE[16*i +: 16]) &&
               (data_addr <= REG_LAST[16*i +: 16]);
    end
    secret_hit = |(hit & REG_SECRET);
    trw_hit    = |(hit & REG_TRW);
    uwp_hit    = |(hit & REG_UWP);
  end

  // Violation classification from the current access.
  always_comb begin
    v1   = !trusted && (r_en || w_en) && secret_hit;
    v2   = trusted && w_en && !trw_hit;
    v3   = !trusted && w_en && uwp_hit;
    viol = v1 || v2 || v3;
  end

  // Leaving KILL needs the hold time expired, the CPU at its reset handler,
  // and the current access itself clean.
  always_comb begin
    exit_ok = (hcnt == 8'd0) && (pc == RESET_HANDLER) && !viol;
  end

  // State and hold-counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_RUN;
      hcnt  <= '0;
    end else begin
      state <= state_nxt;
      hcnt  <= hcnt_nxt;
    end
  end

  // Next-state logic and combinational reset request.
  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    reset     = 1'b0;
    case (state)
      ST_RUN: begin
        reset = viol;
        if (viol) begin
          state_nxt = ST_KILL;
          hcnt_nxt  = HOLD_LOAD;
        end
      end
      ST_KILL: begin
        reset = !exit_ok;
        if (exit_ok) begin
          state_nxt = ST_RUN;
        end else if (hcnt != 8'd0) begin
          hcnt_nxt = hcnt - 8'd1;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        hcnt_nxt  = '0;
      end
    endcase
  end

`ifdef XSTACK_VIOL_LOG_EN
  logic        go_kill;
  logic [2:0]  cause_q;
  logic [15:0] addr_q;
  logic [7:0]  cnt_q;

  assign go_kill = (state == ST_RUN) && viol;

  // Violation log: a new RUN->KILL entry takes priority over a clear, and
  // then restarts the count at one instead of zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cause_q <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else if (go_kill) begin
      cause_q <= {v3, v2, v1};
      addr_q  <= data_addr;
      if (clr_log) begin
        cnt_q <= 8'd1;
      end else if (cnt_q != 8'hFF) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end else if (clr_log) begin
      cause_q <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end
  end

  assign viol_cause = cause_q;
  assign viol_addr  = addr_q;
  assign viol_cnt   = cnt_q;
`else
  logic log_unused;

  assign log_unused = clr_log;
  assign viol_cause = '0;
  assign viol_addr  = '0;
  assign viol_cnt   = '0;
`endif

endmodule

// File: tb/tb_xstack_monitor.sv
// Self-checking bench for xstack_monitor: directed scenarios plus randomized
// traffic checked against a region-table / kill-cycle-count reference model.
module tb_xstack_monitor;

`ifdef XSTACK_VIOL_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  localparam int HOLD_MIN = 4;

  // Region table: index = region number.
  localparam logic [15:0] RB [4] = '{16'hA000, 16'h8000, 16'h9000, 16'hFEFE};
  localparam logic [15:0] RL [4] = '{16'hAFFF, 16'h801E, 16'h901F, 16'hFF1C};
  localparam bit          RSEC [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  localparam bit          RTRW [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  localparam bit          RUWP [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] pc = 16'h4000;
  logic [15:0] data_addr = 16'h0000;
  logic        r_en = 1'b0;
  logic        w_en = 1'b0;
  logic        clr_log = 1'b0;
  logic        reset;
  logic [2:0]  viol_cause;
  logic [15:0] viol_addr;
  logic [7:0]  viol_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  bit          m_kill;
  int          m_k;        // 1-based index of the current KILL cycle
  logic [2:0]  m_cause;
  logic [15:0] m_addr;
  int          m_cnt;
  logic [2:0]  cur_v;
  logic        exp_reset;

  always #5 clk = ~clk;

  xstack_monitor #(.HOLD_MIN(HOLD_MIN)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pc         (pc),
    .data_addr  (data_addr),
    .r_en       (r_en),
    .w_en       (w_en),
    .clr_log    (clr_log),
    .reset      (reset),
    .viol_cause (viol_cause),
    .viol_addr  (viol_addr),
    .viol_cnt   (viol_cnt)
  );

  function automatic logic [2:0] ref_v(input logic [15:0] p, input logic [15:0] a,
                                       input logic r, input logic w);
    bit t, sec, trw, uwp;
    t = (p >= 16'hE000) && (p <= 16'hEFFE);
    sec = 0; trw = 0; uwp = 0;
    for (int i = 0; i < 4; i++) begin
      if (a >= RB[i] && a <= RL[i]) begin
        sec |= RSEC[i];
        trw |= RTRW[i];
        uwp |= RUWP[i];
      end
    end
    return {(!t && w && uwp), (t && w && !trw), (!t && (r || w) && sec)};
  endfunction

  task automatic model_reset();
    m_kill = 0; m_k = 0; m_cause = '0; m_addr = '0; m_cnt = 0;
  endtask

  task automatic model_eval();
    cur_v = ref_v(pc, data_addr, r_en, w_en);
    if (!m_kill) exp_reset = |cur_v;
    else exp_reset = !(m_k >= HOLD_MIN && pc == 16'hFFFE && cur_v == 3'b000);
  endtask

  task automatic model_commit();
    if (!m_kill && cur_v != 3'b000) begin
      m_kill = 1; m_k = 1;
      if (LOG_EN) begin
        m_cause = cur_v;
        m_addr  = data_addr;
        m_cnt   = clr_log ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
      end
    end else begin
      if (m_kill) begin
        if (m_k >= HOLD_MIN && pc == 16'hFFFE && cur_v == 3'b000) begin
          m_kill = 0; m_k = 0;
        end else if (m_k < 1000) begin
          m_k++;
        end
      end
      if (LOG_EN && clr_log) begin
        m_cause = '0; m_addr = '0; m_cnt = 0;
      end
    end
  endtask

  task automatic drive(input logic [15:0] p, input logic [15:0] a,
                       input logic r, input logic w, input logic c);
    @(negedge clk);
    pc = p; data_addr = a; r_en = r; w_en = w; clr_log = c;
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
  endtask

  task automatic recover();
    for (int n = 0; n < 16 && m_kill; n++) begin
      drive(16'hFFFE, 16'h0000, 1'b0, 1'b0, 1'b0);
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    pc = 16'h4000; data_addr = 16'h0000; r_en = 0; w_en = 0; clr_log = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_cmp++; if (reset !== 1'b0) begin n_bad++; $display("FAIL rst_reset: got %b want 0", reset); end
    n_cmp++; if (viol_cause !== 3'b000) begin n_bad++; $display("FAIL rst_cause: got %b want 000", viol_cause); end
    n_cmp++; if (viol_addr !== 16'h0000) begin n_bad++; $display("FAIL rst_addr: got %h want 0000", viol_addr); end
    n_cmp++; if (viol_cnt !== 8'h00) begin n_bad++; $display("FAIL rst_cnt: got %0d want 0", viol_cnt); end
    data_addr = 16'hA010; r_en = 1'b1; #1;
    n_cmp++; if (reset !== 1'b1) begin n_bad++; $display("FAIL rst_comb_viol: got %b want 1", reset); end
    @(posedge clk); @(negedge clk);
    data_addr = 16'h0000; r_en = 1'b0; #1;
    n_cmp++; if (reset !== 1'b0) begin n_bad++; $display("FAIL rst_no_kill: got %b want 0", reset); end
    n_cmp++; if (viol_cnt !== 8'h00) begin n_bad++; $display("FAIL rst_no_log: got %0d want 0", viol_cnt); end
    reset_n = 1'b1;
  endtask

  task automatic test_v1();
    drive(16'h4000, 16'hA010, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (reset !== 1'b1) begin n_bad++; $display("FAIL v1_same_cycle: got %b want 1", reset); end
    tick();
    drive(16'h4000, 16'h0000, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (reset !== 1'b1) begin n_bad++; $display("FAIL v1_kill: got %b want 1", reset); end
    n_cmp++; if (viol_cause !== (LOG_EN ? 3'b001 : 3'b000)) begin n_bad++; $display("FAIL v1_cause: got %b want %b", viol_cause, LOG_EN ? 3'b001 : 3'b000); end
    n_cmp++; if (viol_addr !== (LOG_EN ? 16'hA010 : 16'h0000)) begin n_bad++; $display("FAIL v1_addr: got %h", viol_addr); end
    n_cmp++; if (viol_cnt !== (LOG_EN ? 8'd1 : 8'd0)) begin n_bad++; $display("FAIL v1_cnt: got %0d want %0d", viol_cnt, LOG_EN ? 1 : 0); end
    recover();
    drive(16'h4000, 16'h0000, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (reset !== 1'b0) begin n_bad++; $display("FAIL v1_back_to_run: got %b want 0", reset); end
  endtask

  task automatic test_v2();
    drive(16'hE100, 16'h0200, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (reset !== 1'b1) begin n_bad++; $display("FAIL v2_reset: got %b want 1", reset); end
    tick();
    drive(16'hE100, 16'h0000, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (viol_cause !== (LOG_EN ? 3'b010 : 3'b000)) begin n_bad++; $display("FAIL v2_cause: got %b", viol_cause); end
    n_cmp++; if (viol_addr !== (LOG_EN ? 16'h0200 : 16'h0000)) begin n_bad++; $display("FAIL v2_addr: got %h", viol_addr); end
    n_cmp++; if (viol_cnt !== (LOG_EN ? 8'd2 : 8'd0)) begin n_bad++; $display("FAIL v2_cnt: got %0d", viol_cnt); end
    recover();
    drive(16'hE100, 16'h9004, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (reset !== 1'b0) begin n_bad++; $display("FAIL v2_trw_ok: got %b want 0", reset); end
    tick();
    drive(16'h4000, 16'h0000, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (reset !== 1'b0) begin n_bad++; $display("FAIL v2_stay_run: got %b want 0", reset); end
  endtask

  task automatic test_v3();
    drive(16'h4000, 16'h9000, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (reset !== 1'b1) begin n_bad++; $display("FAIL v3_reset: got %b want 1", reset); end
    tick();
    drive(16'h4000, 16'h0000, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (viol_cause !== (LOG_EN ? 3'b100 : 3'b000)) begin n_bad++; $display("FAIL v3_cause: got %b", viol_cause); end
    n_cmp++; if (viol_addr !== (LOG_EN ? 16'h9000 : 16'h0000)) begin n_bad++; $display("FAIL v3_addr: got %h", viol_addr); end
    n_cmp++; if (viol_cnt !== (LOG_EN ? 8'd3 : 8'd0)) begin n_bad++; $display("FAIL v3_cnt: got %0d", viol_cnt); end
    recover();
    drive(16'h4000, 16'h9000, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (reset !== 1'b0) begin n_bad++; $display("FAIL v3_read_ok: got %b want 0", reset); end
    tick();
  endtask

  task automatic test_hold();
    drive(16'h4000, 16'hA010, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (reset !== 1'b1) begin n_bad++; $display("FAIL hold_entry: got %b want 1", reset); end
    tick();
    for (int k = 1; k <= 4; k++) begin
      drive(16'hFFFE, 16'h0000, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (reset !== (k < 4)) begin n_bad++; $display("FAIL hold_k%0d: got %b want %b", k, reset, k < 4); end
      tick();
    end
    drive(16'h4000, 16'h0000, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (reset !== 1'b0) begin n_bad++; $display("FAIL hold_run_after: got %b want 0", reset); end
    // A violation at the handler blocks exit but is not logged.
    drive(16'h4000, 16'hA010, 1'b1, 1'b0, 1'b0);
    tick();
    for (int k = 1; k <= 3; k++) begin
      drive(16'hFFFE, 16'h0000, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(16'hFFFE, 16'hFEFE, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (reset !== 1'b1) begin n_bad++; $display("FAIL hold_blocked: got %b want 1", reset); end
    tick();
    drive(16'hFFFE, 16'h0000, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (reset !== 1'b0) begin n_bad++; $display("FAIL hold_exit_late: got %b want 0", reset); end
    n_cmp++; if (viol_addr !== (LOG_EN ? 16'hA010 : 16'h0000)) begin n_bad++; $display("FAIL hold_no_relog: got %h", viol_addr); end
    n_cmp++; if (viol_cnt !== (LOG_EN ? 8'd5 : 8'd0)) begin n_bad++; $display("FAIL hold_cnt: got %0d", viol_cnt); end
    tick();
  endtask

  task automatic test_clr_sat();
    drive(16'h4000, 16'h0000, 1'b0, 1'b0, 1'b1);
    tick();
    drive(16'h4000, 16'h0000, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (viol_cnt !== 8'd0) begin n_bad++; $display("FAIL clr_cnt: got %0d want 0", viol_cnt); end
    n_cmp++; if (viol_addr !== 16'h0000) begin n_bad++; $display("FAIL clr_addr: got %h want 0000", viol_addr); end
    for (int n = 0; n < 300; n++) begin
      drive(16'h4000, (n % 2) ? 16'hFF00 : 16'hA010, 1'b1, 1'b0, 1'b0);
      tick();
      recover();
    end
    drive(16'h4000, 16'h0000, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (viol_cnt !== (LOG_EN ? 8'd255 : 8'd0)) begin n_bad++; $display("FAIL sat_cnt: got %0d want %0d", viol_cnt, LOG_EN ? 255 : 0); end
    drive(16'h4000, 16'h9000, 1'b0, 1'b1, 1'b1);
    tick();
    drive(16'h4000, 16'h0000, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (viol_cnt !== (LOG_EN ? 8'd1 : 8'd0)) begin n_bad++; $display("FAIL clr_and_viol_cnt: got %0d", viol_cnt); end
    n_cmp++; if (viol_cause !== (LOG_EN ? 3'b100 : 3'b000)) begin n_bad++; $display("FAIL clr_and_viol_cause: got %b", viol_cause); end
    recover();
  endtask

  task automatic test_async_reset();
    drive(16'h4000, 16'hA010, 1'b1, 1'b0, 1'b0);
    tick();
    drive(16'h4000, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    drive(16'h4000, 16'h0000, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (reset !== 1'b1) begin n_bad++; $display("FAIL ar_in_kill: got %b want 1", reset); end
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (reset !== 1'b0) begin n_bad++; $display("FAIL ar_reset: got %b want 0", reset); end
    n_cmp++; if (viol_cnt !== 8'd0) begin n_bad++; $display("FAIL ar_cnt: got %0d want 0", viol_cnt); end
    n_cmp++; if (viol_cause !== 3'b000) begin n_bad++; $display("FAIL ar_cause: got %b want 000", viol_cause); end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    drive(16'h4000, 16'h0000, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (reset !== 1'b0) begin n_bad++; $display("FAIL ar_run: got %b want 0", reset); end
    drive(16'h4000, 16'hA010, 1'b1, 1'b0, 1'b0);
    tick();
    drive(16'h4000, 16'h0000, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (viol_cnt !== (LOG_EN ? 8'd1 : 8'd0)) begin n_bad++; $display("FAIL ar_cnt_restart: got %0d", viol_cnt); end
    recover();
  endtask

  task automatic test_random();
    logic [15:0] p, a;
    int r;
    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 3))
        0: p = 16'($urandom);
        1: p = 16'hE000 + 16'($urandom_range(0, 16'h0FFE));
        2: p = 16'hFFFE;
        default: begin
          case ($urandom_range(0, 3))
            0: p = 16'hDFFF;
            1: p = 16'hE000;
            2: p = 16'hEFFE;
            default: p = 16'hEFFF;
          endcase
        end
      endcase
      if ($urandom_range(0, 3) == 0) begin
        a = 16'($urandom);
      end else begin
        r = $urandom_range(0, 3);
        case ($urandom_range(0, 4))
          0: a = RB[r] - 16'd1;
          1: a = RB[r];
          2: a = RL[r];
          3: a = RL[r] + 16'd1;
          default: a = RB[r] + 16'((RL[r] - RB[r]) / 2);
        endcase
      end
      drive(p, a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0));
      n_cmp++; if (reset !== exp_reset) begin n_bad++; $display("FAIL rnd_reset[%0d]: got %b want %b pc=%h a=%h", n, reset, exp_reset, pc, data_addr); end
      n_cmp++; if (viol_cause !== m_cause) begin n_bad++; $display("FAIL rnd_cause[%0d]: got %b want %b", n, viol_cause, m_cause); end
      n_cmp++; if (viol_addr !== m_addr) begin n_bad++; $display("FAIL rnd_addr[%0d]: got %h want %h", n, viol_addr, m_addr); end
      n_cmp++; if (viol_cnt !== 8'(m_cnt)) begin n_bad++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", n, viol_cnt, m_cnt); end
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_v1();
    test_v2();
    test_v3();
    test_hold();
    test_clr_sat();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
